// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mem_pkg
//  Description : Shared encodings for the cpu memory port. Covers the access
//                sizes, the fault codes, the port FSM states and the channel
//                that owns the current transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

    // Access sizes (i_ls_size encoding)
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    // Completion fault codes (o_if_fault / o_ls_fault)
    localparam logic [1:0] FAULT_OK      = 2'b00;
    localparam logic [1:0] FAULT_MISAL   = 2'b01;
    localparam logic [1:0] FAULT_BUSERR  = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        CH_IF = 1'b0,
        CH_LS = 1'b1
    } chan_t;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational little-endian lane logic. From the byte offset
//                within a bus word and the access size it produces the byte
//                enables, the lane-replicated store data, the extracted and
//                sign/zero-extended load data and the misalignment flag.
//  Ports       : i_off     byte offset inside the bus word
//                i_size    access size (SIZE_B/H/W/D)
//                i_signed  sign-extend the load result
//                i_wdata   right-justified store data
//                i_rdata   raw bus read data
//                o_sel     byte-lane enables
//                o_wdata   store data replicated across the lanes
//                o_rdata   extracted, extended load data
//                o_misal   access misaligned or size illegal for DW
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import cpu_mem_pkg::*;
#(
    parameter int DW   = 32,
    parameter int OFFW = $clog2(DW / 8)
) (
    input  logic [OFFW-1:0]   i_off,
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    input  logic [DW-1:0]     i_wdata,
    input  logic [DW-1:0]     i_rdata,
    output logic [DW/8-1:0]   o_sel,
    output logic [DW-1:0]     o_wdata,
    output logic [DW-1:0]     o_rdata,
    output logic              o_misal
);

    localparam int NB = DW / 8;

    logic [DW-1:0] w_shift;   // read data with the addressed byte moved to lane 0
    logic [DW-1:0] w_mask;    // bits that belong to the access
    logic          w_sbit;    // sign bit of the access

    always_comb begin
        o_sel   = '0;
        o_wdata = i_wdata;
        o_misal = 1'b0;
        w_mask  = '1;
        w_sbit  = 1'b0;
        w_shift = i_rdata >> {i_off, 3'b000};
        case (i_size)
            SIZE_B: begin
                o_sel   = NB'(1) << i_off;
                o_wdata = {NB{i_wdata[7:0]}};
                w_mask  = DW'(8'hFF);
                w_sbit  = w_shift[7];
            end
            SIZE_H: begin
                o_sel   = NB'(2'b11) << i_off;
                o_wdata = {(DW/16){i_wdata[15:0]}};
                w_mask  = DW'(16'hFFFF);
                w_sbit  = w_shift[15];
                o_misal = i_off[0];
            end
            SIZE_W: begin
                o_sel   = NB'(4'hF) << i_off;
                o_wdata = {(DW/32){i_wdata[31:0]}};
                w_mask  = DW'(32'hFFFF_FFFF);
                w_sbit  = w_shift[31];
                o_misal = |i_off[1:0];
            end
            default: begin
                // A dword fills the whole bus; it only exists on a 64-bit bus.
                o_sel   = '1;
                o_misal = (DW == 32) ? 1'b1 : |i_off;
            end
        endcase
        // Bits above the access are either sign copies or zeros.
        o_rdata = (w_shift & w_mask) | ({DW{i_signed & w_sbit}} & ~w_mask);
    end

endmodule
`default_nettype wire

// File: rtl/cpu_mem_port.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mem_port
//  Description : Shared memory port. Arbitrates an instruction-fetch channel
//                and a load/store channel (load/store has priority) onto one
//                pipelined Wishbone master, with lane steering, alignment
//                checks, bus-error and timeout faults.
//  Ports       : clk, reset (synchronous, active-low)
//                i_if_*  / o_if_*  fetch request and result channel
//                i_ls_*  / o_ls_*  load/store request and result channel
//                o_wb_* / i_wb_*   Wishbone pipelined master
//                o_busy            FSM not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_port
    import cpu_mem_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    // fetch channel
    input  logic              i_if_req,
    input  logic [AW-1:0]     i_if_addr,
    output logic              o_if_ready,
    output logic              o_if_valid,
    output logic [DW-1:0]     o_if_data,
    output logic [1:0]        o_if_fault,
    // load/store channel
    input  logic              i_ls_req,
    input  logic              i_ls_we,
    input  logic [AW-1:0]     i_ls_addr,
    input  logic [1:0]        i_ls_size,
    input  logic              i_ls_signed,
    input  logic [DW-1:0]     i_ls_wdata,
    output logic              o_ls_ready,
    output logic              o_ls_valid,
    output logic [DW-1:0]     o_ls_rdata,
    output logic [1:0]        o_ls_fault,
    // Wishbone pipelined master
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [AW-1:0]     o_wb_addr,
    output logic [DW-1:0]     o_wb_data,
    output logic [DW/8-1:0]   o_wb_sel,
    input  logic [DW-1:0]     i_wb_data,
    input  logic              i_wb_ack,
    input  logic              i_wb_stall,
    input  logic              i_wb_err,
    output logic              o_busy
);

    localparam int         OFFW       = $clog2(DW / 8);
    localparam int         TW         = $clog2(TIMEOUT + 1);
    localparam logic [1:0] FETCH_SIZE = (DW == 64) ? SIZE_D : SIZE_W;

    state_t             r_state;
    chan_t              r_chan;
    logic               r_we;
    logic               r_signed;
    logic [1:0]         r_size;
    logic [OFFW-1:0]    r_off;
    logic [TW-1:0]      r_tcnt;

    logic               w_idle;
    logic               w_accept;
    logic               w_req_we;
    logic [OFFW-1:0]    w_off;
    logic [1:0]         w_size;
    logic               w_signed;
    logic [DW/8-1:0]    w_sel;
    logic [DW-1:0]      w_wdata;
    logic [DW-1:0]      w_rdata;
    logic               w_misal;
    logic [1:0]         w_fault;
    logic [DW-1:0]      w_done_data;

    // Readies are held low while reset is asserted so every output reads 0.
    assign w_idle     = (r_state == ST_IDLE) && reset;
    assign o_ls_ready = w_idle;
    assign o_if_ready = w_idle && !i_ls_req;
    assign w_accept   = w_idle && (i_ls_req || i_if_req);
    assign w_req_we   = i_ls_req && i_ls_we;
    assign o_busy     = (r_state != ST_IDLE);

    // Lane logic sees the incoming request while idle (to steer and check it
    // at accept) and the latched request afterwards (to extract read data).
    always_comb begin
        if (r_state != ST_IDLE) begin
            w_off    = r_off;
            w_size   = r_size;
            w_signed = r_signed;
        end else if (i_ls_req) begin
            w_off    = i_ls_addr[OFFW-1:0];
            w_size   = i_ls_size;
            w_signed = i_ls_signed;
        end else begin
            w_off    = i_if_addr[OFFW-1:0];
            w_size   = FETCH_SIZE;
            w_signed = 1'b0;
        end
    end

    mem_lane_align #(
        .DW   (DW),
        .OFFW (OFFW)
    ) u_lane (
        .i_off    (w_off),
        .i_size   (w_size),
        .i_signed (w_signed),
        .i_wdata  (i_ls_wdata),
        .i_rdata  (i_wb_data),
        .o_sel    (w_sel),
        .o_wdata  (w_wdata),
        .o_rdata  (w_rdata),
        .o_misal  (w_misal)
    );

    // Completion status in WAIT: err beats ack; neither means timeout.
    always_comb begin
        w_fault     = FAULT_TIMEOUT;
        w_done_data = '0;
        if (i_wb_err) begin
            w_fault = FAULT_BUSERR;
        end else if (i_wb_ack) begin
            w_fault     = FAULT_OK;
            w_done_data = r_we ? '0 : w_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_chan     <= CH_IF;
            r_we       <= 1'b0;
            r_signed   <= 1'b0;
            r_size     <= SIZE_B;
            r_off      <= '0;
            r_tcnt     <= '0;
            o_if_valid <= 1'b0;
            o_if_data  <= '0;
            o_if_fault <= FAULT_OK;
            o_ls_valid <= 1'b0;
            o_ls_rdata <= '0;
            o_ls_fault <= FAULT_OK;
            o_wb_cyc   <= 1'b0;
            o_wb_stb   <= 1'b0;
            o_wb_we    <= 1'b0;
            o_wb_addr  <= '0;
            o_wb_data  <= '0;
            o_wb_sel   <= '0;
        end else begin
            // Result outputs are single-cycle; they read 0 outside the pulse.
            o_if_valid <= 1'b0;
            o_if_data  <= '0;
            o_if_fault <= FAULT_OK;
            o_ls_valid <= 1'b0;
            o_ls_rdata <= '0;
            o_ls_fault <= FAULT_OK;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_chan   <= i_ls_req ? CH_LS : CH_IF;
                        r_we     <= w_req_we;
                        r_size   <= w_size;
                        r_signed <= w_signed;
                        r_off    <= w_off;
                        if (w_misal) begin
                            // Rejected without touching the bus.
                            r_state <= ST_DONE;
                            if (i_ls_req) begin
                                o_ls_valid <= 1'b1;
                                o_ls_fault <= FAULT_MISAL;
                            end else begin
                                o_if_valid <= 1'b1;
                                o_if_fault <= FAULT_MISAL;
                            end
                        end else begin
                            r_state   <= ST_REQ;
                            o_wb_cyc  <= 1'b1;
                            o_wb_stb  <= 1'b1;
                            o_wb_we   <= w_req_we;
                            o_wb_sel  <= w_sel;
                            o_wb_data <= w_wdata;
                            o_wb_addr <= i_ls_req ? {i_ls_addr[AW-1:OFFW], {OFFW{1'b0}}}
                                                  : {i_if_addr[AW-1:OFFW], {OFFW{1'b0}}};
                        end
                    end
                end
                ST_REQ: begin
                    if (!i_wb_stall) begin
                        o_wb_stb <= 1'b0;
                        r_tcnt   <= '0;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_wb_err || i_wb_ack || (r_tcnt == TW'(TIMEOUT - 1))) begin
                        o_wb_cyc <= 1'b0;
                        r_state  <= ST_DONE;
                        if (r_chan == CH_LS) begin
                            o_ls_valid <= 1'b1;
                            o_ls_rdata <= w_done_data;
                            o_ls_fault <= w_fault;
                        end else begin
                            o_if_valid <= 1'b1;
                            o_if_data  <= w_done_data;
                            o_if_fault <= w_fault;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_mem_port
//  Description : Self-checking bench for cpu_mem_port (AW=32, DW=32,
//                TIMEOUT=4). Table of single transactions plus hand-written
//                arbitration, stall/timeout, error and reset sequences.
//                Expected completions are queued at accept and checked when
//                a valid pulse appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_port;

    logic        clk;
    logic        reset;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_ready;
    logic        o_if_valid;
    logic [31:0] o_if_data;
    logic [1:0]  o_if_fault;
    logic        i_ls_req;
    logic        i_ls_we;
    logic [31:0] i_ls_addr;
    logic [1:0]  i_ls_size;
    logic        i_ls_signed;
    logic [31:0] i_ls_wdata;
    logic        o_ls_ready;
    logic        o_ls_valid;
    logic [31:0] o_ls_rdata;
    logic [1:0]  o_ls_fault;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;
    logic [31:0] i_wb_data;
    logic        i_wb_ack;
    logic        i_wb_stall;
    logic        i_wb_err;
    logic        o_busy;

    cpu_mem_port #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_if_req    (i_if_req),
        .i_if_addr   (i_if_addr),
        .o_if_ready  (o_if_ready),
        .o_if_valid  (o_if_valid),
        .o_if_data   (o_if_data),
        .o_if_fault  (o_if_fault),
        .i_ls_req    (i_ls_req),
        .i_ls_we     (i_ls_we),
        .i_ls_addr   (i_ls_addr),
        .i_ls_size   (i_ls_size),
        .i_ls_signed (i_ls_signed),
        .i_ls_wdata  (i_ls_wdata),
        .o_ls_ready  (o_ls_ready),
        .o_ls_valid  (o_ls_valid),
        .o_ls_rdata  (o_ls_rdata),
        .o_ls_fault  (o_ls_fault),
        .o_wb_cyc    (o_wb_cyc),
        .o_wb_stb    (o_wb_stb),
        .o_wb_we     (o_wb_we),
        .o_wb_addr   (o_wb_addr),
        .o_wb_data   (o_wb_data),
        .o_wb_sel    (o_wb_sel),
        .i_wb_data   (i_wb_data),
        .i_wb_ack    (i_wb_ack),
        .i_wb_stall  (i_wb_stall),
        .i_wb_err    (i_wb_err),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          fetch;
        bit          we;
        logic [31:0] addr;
        logic [1:0]  size;
        bit          sgn;
        logic [31:0] wdata;
        logic [31:0] bus;
        logic [3:0]  sel;
        logic [31:0] wbdata;
        logic [31:0] rdata;
        logic [1:0]  fault;
    } vec_t;

    typedef struct {
        bit          ls;
        logic [31:0] data;
        logic [1:0]  fault;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    vec_t vecs[14];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_cnt = 0;
    int   last_ls_valid = -100;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    function automatic vec_t mk(bit f, bit we, logic [31:0] a, logic [1:0] sz, bit sg,
                                logic [31:0] wd, logic [31:0] bus, logic [3:0] sel,
                                logic [31:0] wbd, logic [31:0] rd, logic [1:0] flt);
        vec_t v;
        v.fetch = f;  v.we = we;   v.addr = a;  v.size = sz; v.sgn = sg;
        v.wdata = wd; v.bus = bus; v.sel = sel; v.wbdata = wbd;
        v.rdata = rd; v.fault = flt;
        return v;
    endfunction

    // Completion monitor: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (o_ls_valid || o_if_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got ls=%0b if=%0b expected none", o_ls_valid, o_if_valid);
            end else begin
                m_e = sb.pop_front();
                chk("valid_chan", o_ls_valid, m_e.ls);
                chk("single_valid", o_ls_valid & o_if_valid, 0);
                chk("result_data", m_e.ls ? o_ls_rdata : o_if_data, m_e.data);
                chk("result_fault", m_e.ls ? o_ls_fault : o_if_fault, m_e.fault);
                chk("cyc_at_valid", o_wb_cyc, 0);
                if (m_e.lat != 0) chk("latency", cyc_cnt - m_e.acc, m_e.lat);
            end
            if (o_ls_valid) last_ls_valid = cyc_cnt;
        end
    end

    // Slave side: hold stall for nstall cycles, then optionally ack/err once.
    task automatic bus_respond(input logic [31:0] rd, input int nstall, input bit ack, input bit err);
        int n = 0;
        while (!o_wb_stb && n < 10) begin @(negedge clk); n++; end
        if (!o_wb_stb) begin fail_now("stb_wait"); return; end
        for (int k = 0; k < nstall; k++) begin
            i_wb_stall = 1'b1;
            @(negedge clk);
            chk("stb_held", o_wb_stb, 1);
        end
        i_wb_stall = 1'b0;
        @(negedge clk);
        chk("stb_drop", {o_wb_cyc, o_wb_stb}, 2'b10);
        if (ack || err) begin
            i_wb_ack = ack; i_wb_err = err; i_wb_data = rd;
            @(negedge clk);
            i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_data = '0;
        end
    endtask

    // Drive one request, wait for its ready and queue its expected result.
    // Returns at the negedge right after the accepting edge.
    task automatic issue(input bit f, input bit we, input logic [31:0] a, input logic [1:0] sz,
                         input bit sg, input logic [31:0] wd, input bit push,
                         input logic [31:0] ed, input logic [1:0] ef, input int lat);
        int   n = 0;
        exp_t e;
        i_if_req = f;  i_if_addr = a;
        i_ls_req = !f; i_ls_we = we; i_ls_addr = a; i_ls_size = sz;
        i_ls_signed = sg; i_ls_wdata = wd;
        #1;
        while (!(f ? o_if_ready : o_ls_ready) && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) fail_now("accept_wait");
        e.ls = !f; e.data = ed; e.fault = ef; e.lat = lat; e.acc = cyc_cnt;
        if (push) sb.push_back(e);
        @(negedge clk);
        i_if_req = 1'b0; i_ls_req = 1'b0; i_ls_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
        if (sb.size() != 0) begin
            fail_now("valid_wait");
            sb.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        issue(v.fetch, v.we, v.addr, v.size, v.sgn, v.wdata, 1'b1, v.rdata, v.fault,
              (v.fault == 2'b00) ? 3 : 1);
        if (v.fault == 2'b00) begin
            chk("req_cyc_stb", {o_wb_cyc, o_wb_stb}, 2'b11);
            chk("wb_addr", o_wb_addr, v.addr & 32'hFFFF_FFFC);
            chk("wb_sel", o_wb_sel, v.sel);
            chk("wb_we", o_wb_we, v.we);
            if (v.we) chk("wb_data", o_wb_data, v.wbdata);
            bus_respond(v.bus, 0, 1'b1, 1'b0);
        end else begin
            chk("no_bus_cycle", o_wb_cyc, 0);
        end
        drain();
    endtask

    initial begin
        int n;
        //            f  we addr           sz sg wdata          bus            sel      wbdata         rdata          flt
        vecs[0]  = mk(1, 0, 32'hb000_0000, 2, 0, 32'h0,         32'hdeadbeef, 4'b1111, 32'h0,         32'hdeadbeef, 2'd0);
        vecs[1]  = mk(0, 0, 32'h1000_0003, 0, 1, 32'h0,         32'h8012_3456, 4'b1000, 32'h0,        32'hffff_ff80, 2'd0);
        vecs[2]  = mk(0, 0, 32'h1000_0003, 0, 0, 32'h0,         32'h8012_3456, 4'b1000, 32'h0,        32'h0000_0080, 2'd0);
        vecs[3]  = mk(0, 1, 32'h2000_0002, 1, 0, 32'h0000_1234, 32'h0,         4'b1100, 32'h1234_1234, 32'h0,        2'd0);
        vecs[4]  = mk(0, 1, 32'h2000_0001, 1, 0, 32'h0000_1234, 32'h0,         4'b0000, 32'h0,        32'h0,         2'd1);
        vecs[5]  = mk(0, 0, 32'h3000_0000, 1, 1, 32'h0,         32'h1234_8001, 4'b0011, 32'h0,        32'hffff_8001, 2'd0);
        vecs[6]  = mk(0, 0, 32'h3000_0002, 1, 0, 32'h0,         32'hfedc_0000, 4'b1100, 32'h0,        32'h0000_fedc, 2'd0);
        vecs[7]  = mk(0, 1, 32'h4000_0001, 0, 0, 32'hffff_ffa5, 32'h0,         4'b0010, 32'ha5a5_a5a5, 32'h0,        2'd0);
        vecs[8]  = mk(0, 1, 32'h4000_0004, 2, 0, 32'hcafe_f00d, 32'h0,         4'b1111, 32'hcafe_f00d, 32'h0,        2'd0);
        vecs[9]  = mk(0, 0, 32'h5000_0008, 2, 1, 32'h0,         32'h8765_4321, 4'b1111, 32'h0,        32'h8765_4321, 2'd0);
        vecs[10] = mk(0, 0, 32'h5000_0000, 3, 0, 32'h0,         32'h0,         4'b0000, 32'h0,        32'h0,         2'd1);
        vecs[11] = mk(1, 0, 32'hb000_0002, 2, 0, 32'h0,         32'h0,         4'b0000, 32'h0,        32'h0,         2'd1);
        vecs[12] = mk(0, 0, 32'h5000_0002, 2, 0, 32'h0,         32'h0,         4'b0000, 32'h0,        32'h0,         2'd1);
        vecs[13] = mk(0, 0, 32'h6000_0001, 0, 1, 32'h0,         32'h0000_7f00, 4'b0010, 32'h0,        32'h0000_007f, 2'd0);

        reset = 1'b0;
        i_if_req = 0; i_if_addr = 0; i_ls_req = 0; i_ls_we = 0; i_ls_addr = 0;
        i_ls_size = 0; i_ls_signed = 0; i_ls_wdata = 0;
        i_wb_data = 0; i_wb_ack = 0; i_wb_stall = 0; i_wb_err = 0;
        repeat (3) @(negedge clk);
        chk("reset_ready", {o_if_ready, o_ls_ready}, 2'b00);
        chk("reset_wb", {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel}, 0);
        chk("reset_valid", {o_if_valid, o_ls_valid, o_busy}, 0);
        chk("reset_data", {o_if_data, o_ls_rdata}, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // Simultaneous requests: load/store first, fetch right after its valid.
        @(negedge clk);
        i_if_req = 1'b1; i_if_addr = 32'hb000_0010;
        i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h7000_0010;
        i_ls_size = 2'd2; i_ls_signed = 1'b0;
        #1;
        chk("arb_ls_ready", o_ls_ready, 1);
        chk("arb_if_ready", o_if_ready, 0);
        begin
            exp_t e;
            e.ls = 1'b1; e.data = 32'h1111_2222; e.fault = 2'd0; e.lat = 3; e.acc = cyc_cnt;
            sb.push_back(e);
        end
        @(negedge clk);
        i_ls_req = 1'b0;
        chk("arb_if_blocked", o_if_ready, 0);
        bus_respond(32'h1111_2222, 0, 1'b1, 1'b0);
        n = 0;
        while (!o_if_ready && n < 20) begin @(negedge clk); n++; end
        chk("arb_if_after_ls", cyc_cnt - last_ls_valid, 1);
        begin
            exp_t e;
            e.ls = 1'b0; e.data = 32'h3333_4444; e.fault = 2'd0; e.lat = 3; e.acc = cyc_cnt;
            sb.push_back(e);
        end
        @(negedge clk);
        i_if_req = 1'b0;
        bus_respond(32'h3333_4444, 0, 1'b1, 1'b0);
        drain();

        // Stall three cycles, then silence: timeout fault.
        issue(0, 0, 32'h7000_0020, 2'd2, 0, 32'h0, 1'b1, 32'h0, 2'd3, 0);
        bus_respond(32'h0, 3, 1'b0, 1'b0);
        drain();

        // err and ack together: bus error wins.
        issue(0, 0, 32'h7000_0030, 2'd2, 0, 32'h0, 1'b1, 32'h0, 2'd2, 0);
        bus_respond(32'hffff_ffff, 0, 1'b1, 1'b1);
        drain();

        // Reset while waiting for ack; a late ack must be ignored.
        issue(0, 0, 32'h7000_0040, 2'd2, 0, 32'h0, 1'b0, 32'h0, 2'd0, 0);
        @(negedge clk);
        chk("rst_in_wait", {o_wb_cyc, o_wb_stb}, 2'b10);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_drop", {o_wb_cyc, o_wb_stb, o_ls_valid, o_busy}, 0);
        reset = 1'b1;
        i_wb_ack = 1'b1; i_wb_data = 32'h5555_5555;
        @(negedge clk);
        i_wb_ack = 1'b0; i_wb_data = 32'h0;
        chk("late_ack_idle", {o_busy, o_ls_valid, o_wb_cyc}, 0);
        @(negedge clk);
        chk("late_ack_novalid", {o_busy, o_ls_valid}, 0);

        repeat (2) @(negedge clk);
        chk("queue_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
